payload_serializer: RTL and testbench



---
 rtl/payload_serializer.sv | 95 +++++++++
 tb/tb_payload_serializer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_serializer.sv
// Pops one DATA_POINTS-word frame from the pre-data buffer and streams it out as
// MSB-first bytes on a valid/ready/last interface, counting completed frames.
module payload_serializer #(
   parameter int N           = 8,
   parameter int DATA_POINTS = 5,
   parameter int CNT_W       = 16
) (
   input  logic                        eth_clk,
   input  logic                        rst_n,
   input  logic [0:DATA_POINTS-1][N:0] buf_data,
   input  logic                        buf_rvalid,
   output logic                        buf_rready,
   output logic [7:0]                  m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast,
   output logic                        busy,
   output logic [CNT_W-1:0]            frame_cnt
);

   localparam int W           = N + 1;
   localparam int BPW         = (N + 8) / 8;
   localparam int FRAME_BYTES = DATA_POINTS * BPW;
   localparam int K_W         = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                        state_q, state_d;
   logic [0:DATA_POINTS-1][W-1:0] frame_q;
   logic [K_W-1:0]                k_q;
   logic                          pop, accept, last;
   logic [BPW*8-1:0]              padded [DATA_POINTS];
   logic [7:0]                    byte_c;

   assign last = (k_q == K_W'(FRAME_BYTES - 1));

   // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
   always_ff @(posedge eth_clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      buf_rready = 1'b0;
      pop        = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         IDLE: begin
            buf_rready = buf_rvalid;
            pop        = buf_rvalid;
            if (buf_rvalid) state_d = SEND;
         end
         SEND: begin
            accept = m_tready;
            if (m_tready && last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the frame register is cleared on reset as well, so no stale frame survives it.
   always_ff @(posedge eth_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q   <= '0;
         k_q       <= '0;
         frame_cnt <= '0;
      end else if (pop) begin
         frame_q <= buf_data;
         k_q     <= '0;
      end else if (accept) begin
         if (last) frame_cnt <= frame_cnt + CNT_W'(1);
         else      k_q       <= k_q + K_W'(1);
      end
   end

   // Byte k is byte (BPW-1 - k%BPW) of word k/BPW, counted from the LSB of the padded word.
   always_comb begin
      byte_c = '0;
      for (int w = 0; w < DATA_POINTS; w++) begin
         padded[w]        = '0;
         padded[w][W-1:0] = frame_q[w];
      end
      for (int i = 0; i < FRAME_BYTES; i++) begin
         if (k_q == K_W'(i)) byte_c = padded[i/BPW][(BPW-1-i%BPW)*8 +: 8];
      end
   end

   assign m_tvalid = (state_q == SEND);
   assign busy     = (state_q == SEND);
   assign m_tlast  = (state_q == SEND) && last;
   assign m_tdata  = (state_q == SEND) ? byte_c : 8'h00;

endmodule

// File: tb/tb_payload_serializer.sv
// Self-checking bench for payload_serializer: a byte-queue model checked every cycle,
// two DUTs (16-bit and 2-bit frame counters) sharing the same stimulus.
module tb_payload_serializer;

   localparam int N   = 8;
   localparam int W   = N + 1;
   localparam int DP  = 5;
   localparam int BPW = (N + 8) / 8;
   localparam int FB  = DP * BPW;

   logic               eth_clk = 1'b0;
   logic               rst_n;
   logic [0:DP-1][N:0] buf_data;
   logic               buf_rvalid, m_tready;

   logic        buf_rready, m_tvalid, m_tlast, busy;
   logic [7:0]  m_tdata;
   logic [15:0] frame_cnt;
   logic        buf_rready_w, m_tvalid_w, m_tlast_w, busy_w;
   logic [7:0]  m_tdata_w;
   logic [1:0]  frame_cnt_w;

   payload_serializer #(.N(N), .DATA_POINTS(DP), .CNT_W(16)) dut (
      .eth_clk(eth_clk), .rst_n(rst_n), .buf_data(buf_data), .buf_rvalid(buf_rvalid),
      .buf_rready(buf_rready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .busy(busy), .frame_cnt(frame_cnt));

   payload_serializer #(.N(N), .DATA_POINTS(DP), .CNT_W(2)) dut_w (
      .eth_clk(eth_clk), .rst_n(rst_n), .buf_data(buf_data), .buf_rvalid(buf_rvalid),
      .buf_rready(buf_rready_w), .m_tdata(m_tdata_w), .m_tvalid(m_tvalid_w), .m_tready(m_tready),
      .m_tlast(m_tlast_w), .busy(busy_w), .frame_cnt(frame_cnt_w));

   always #5 eth_clk = ~eth_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a queue of bytes still owed downstream
   int                 exp_q[$];
   int                 exp_cnt = 0;
   bit                 do_pop, do_acc;
   logic [0:DP-1][N:0] snap;

   function automatic void push_frame(input logic [0:DP-1][N:0] f);
      for (int w = 0; w < DP; w++)
         for (int b = BPW - 1; b >= 0; b--)
            exp_q.push_back((int'(f[w]) >> (8 * b)) & 255);
   endfunction

   initial begin
      forever begin
         @(negedge eth_clk);
         do_pop = 1'b0;
         do_acc = 1'b0;
         if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            check("rst_rready", buf_rready, 0);
            check("rst_tvalid", m_tvalid, 0);
            check("rst_tlast",  m_tlast, 0);
            check("rst_tdata",  m_tdata, 0);
            check("rst_busy",   busy, 0);
            check("rst_cnt",    frame_cnt, 0);
            check("rst_cnt_w",  frame_cnt_w, 0);
         end else begin
            do_pop = (exp_q.size() == 0) && buf_rvalid;
            do_acc = (exp_q.size() != 0) && m_tready;
            snap   = buf_data;
            check("rready",   buf_rready, do_pop);
            check("rready_w", buf_rready_w, do_pop);
            check("tvalid",   m_tvalid, exp_q.size() != 0);
            check("tvalid_w", m_tvalid_w, exp_q.size() != 0);
            check("busy",     busy, exp_q.size() != 0);
            check("busy_w",   busy_w, exp_q.size() != 0);
            check("cnt",      frame_cnt, exp_cnt % 65536);
            check("cnt_w",    frame_cnt_w, exp_cnt % 4);
            if (exp_q.size() != 0) begin
               check("tdata",   m_tdata, exp_q[0]);
               check("tdata_w", m_tdata_w, exp_q[0]);
               check("tlast",   m_tlast, exp_q.size() == 1);
               check("tlast_w", m_tlast_w, exp_q.size() == 1);
            end else begin
               check("tlast_idle", m_tlast, 0);
            end
         end
         @(posedge eth_clk);
         if (rst_n) begin
            if (do_acc) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) exp_cnt++;
            end
            if (do_pop) push_frame(snap);
         end
      end
   end

   // ---------------- monitor: event statistics for the directed checks
   int cyc = 0, n_pop = 0, n_acc = 0, n_last = 0;
   int pop_cyc[$];
   int acc_log[$];

   initial begin
      forever begin
         @(negedge eth_clk);
         cyc++;
         if (rst_n) begin
            if (buf_rready && buf_rvalid) begin
               n_pop++;
               pop_cyc.push_back(cyc);
            end
            if (m_tvalid && m_tready) begin
               n_acc++;
               acc_log.push_back(int'(m_tdata));
               if (m_tlast) n_last++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus
   localparam logic [0:DP-1][N:0] BASIC = {9'h1C0, 9'h0FF, 9'h0EE, 9'h00F, 9'h1F0};
   int basic_bytes[FB] = '{'h01, 'hC0, 'h00, 'hFF, 'h00, 'hEE, 'h00, 'h0F, 'h01, 'hF0};

   task automatic step();
      @(posedge eth_clk);
      #1;
   endtask

   function automatic logic [0:DP-1][N:0] rand_frame();
      logic [0:DP-1][N:0] f;
      for (int w = 0; w < DP; w++) f[w] = W'($urandom);
      return f;
   endfunction

   task automatic wait_last(input int target, input int budget, input string name);
      int g = 0;
      while (n_last < target && g < budget) begin
         step();
         g++;
      end
      check({name, "_timeout"}, n_last >= target, 1);
   endtask

   task automatic check_basic_log(input string name);
      check({name, "_nbytes"}, acc_log.size(), FB);
      for (int i = 0; i < FB; i++)
         check({name, "_byte"}, (i < acc_log.size()) ? acc_log[i] : -1, basic_bytes[i]);
   endtask

   int base_pop, base_last, base_acc, g;

   initial begin
      rst_n      = 1'b0;
      buf_data   = '0;
      buf_rvalid = 1'b0;
      m_tready   = 1'b0;
      repeat (3) step();
      check("reset_tvalid", m_tvalid, 0);
      check("reset_cnt", frame_cnt, 0);
      rst_n = 1'b1;
      step();

      // Basic frame, m_tready held high
      acc_log.delete();
      base_pop  = n_pop;
      base_last = n_last;
      buf_data   = BASIC;
      buf_rvalid = 1'b1;
      m_tready   = 1'b1;
      step();
      buf_rvalid = 1'b0;
      buf_data   = rand_frame();
      check("model_basic_len", exp_q.size(), FB);
      for (int i = 0; i < FB; i++)
         check("model_basic_byte", (i < exp_q.size()) ? exp_q[i] : -1, basic_bytes[i]);
      wait_last(base_last + 1, 40, "basic");
      check_basic_log("basic");
      check("basic_pops", n_pop - base_pop, 1);
      check("basic_lasts", n_last - base_last, 1);
      check("basic_cnt", frame_cnt, 1);

      // Backpressure: m_tready toggles every cycle
      acc_log.delete();
      base_pop  = n_pop;
      base_last = n_last;
      buf_data   = BASIC;
      buf_rvalid = 1'b1;
      m_tready   = 1'b0;
      step();
      buf_rvalid = 1'b0;
      g = 0;
      while (n_last < base_last + 1 && g < 100) begin
         m_tready = ~m_tready;
         step();
         g++;
      end
      check("bp_timeout", n_last >= base_last + 1, 1);
      check_basic_log("bp");
      check("bp_pops", n_pop - base_pop, 1);
      check("bp_cnt", frame_cnt, 2);

      // Back-to-back: buf_rvalid held for three frames
      acc_log.delete();
      pop_cyc.delete();
      base_pop  = n_pop;
      base_last = n_last;
      m_tready   = 1'b1;
      buf_rvalid = 1'b1;
      buf_data   = rand_frame();
      g = 0;
      while (n_pop < base_pop + 3 && g < 60) begin
         step();
         buf_data = rand_frame();
         g++;
      end
      buf_rvalid = 1'b0;
      check("b2b_pop_timeout", n_pop >= base_pop + 3, 1);
      wait_last(base_last + 3, 40, "b2b");
      check("b2b_pops", n_pop - base_pop, 3);
      check("b2b_gap0", (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1, 11);
      check("b2b_gap1", (pop_cyc.size() >= 3) ? pop_cyc[2] - pop_cyc[1] : -1, 11);
      check("b2b_bytes", acc_log.size(), 3 * FB);
      check("b2b_lasts", n_last - base_last, 3);
      check("b2b_cnt", frame_cnt, 5);
      check("b2b_cnt_wrap", frame_cnt_w, 1);

      // No pop while busy: buffer side churns during SEND
      base_pop  = n_pop;
      base_last = n_last;
      buf_data   = rand_frame();
      buf_rvalid = 1'b1;
      m_tready   = 1'b1;
      step();
      g = 0;
      while (exp_q.size() > 2 && g < 100) begin
         buf_rvalid = 1'($urandom_range(0, 1));
         buf_data   = rand_frame();
         m_tready   = 1'($urandom_range(0, 1));
         step();
         g++;
      end
      buf_rvalid = 1'b0;
      m_tready   = 1'b1;
      wait_last(base_last + 1, 20, "busy");
      check("busy_pops", n_pop - base_pop, 1);
      check("busy_cnt", frame_cnt, 6);

      // Reset mid-frame after the fourth accepted byte
      base_acc   = n_acc;
      buf_data   = rand_frame();
      buf_rvalid = 1'b1;
      m_tready   = 1'b1;
      step();
      buf_rvalid = 1'b0;
      g = 0;
      while (n_acc < base_acc + 4 && g < 20) begin
         step();
         g++;
      end
      check("mid_acc_timeout", n_acc - base_acc, 4);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", m_tvalid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cnt", frame_cnt, 0);
      check("mid_rst_cnt_w", frame_cnt_w, 0);
      step();
      step();
      rst_n = 1'b1;
      base_acc = n_acc;
      base_pop = n_pop;
      repeat (6) step();
      check("post_rst_bytes", n_acc - base_acc, 0);
      check("post_rst_pops", n_pop - base_pop, 0);
      check("post_rst_tvalid", m_tvalid, 0);

      // Randomized traffic, long enough to wrap the 2-bit counter
      g = 0;
      while (exp_cnt < 7 && g < 800) begin
         buf_rvalid = ($urandom_range(0, 3) != 0);
         m_tready   = ($urandom_range(0, 3) != 0);
         buf_data   = rand_frame();
         step();
         g++;
      end
      check("rand_timeout", exp_cnt >= 7, 1);
      buf_rvalid = 1'b0;
      m_tready   = 1'b1;
      g = 0;
      while (exp_q.size() != 0 && g < 40) begin
         step();
         g++;
      end
      check("rand_drain", exp_q.size(), 0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
